// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot billing controller.
package parking_pkg;
  localparam int TIME_W      = 8;
  localparam int FEE_W       = 10;
  localparam int RATE_DEF    = 2;
  localparam int FEE_CAP_DEF = 400;

  typedef enum logic [2:0] {
    IDLE, ENTRY, EXIT_CALC, EXIT_DONE, RELEASE
  } state_e;

  // Multiply at full width so the cap compare sees the untruncated product.
  function automatic logic [FEE_W-1:0] cap_fee(input logic [TIME_W:0] el,
                                               input int rate, input int cap);
    logic [31:0] p;
    p = 32'(el) * 32'(rate);
    if (p > 32'(cap)) return FEE_W'(cap);
    return FEE_W'(p);
  endfunction
endpackage

// File: rtl/elapsed_calc.sv
// Wrap-aware tick difference between an entry stamp and the current time.
module elapsed_calc
  import parking_pkg::*;
(
  input  logic [TIME_W-1:0] now,
  input  logic [TIME_W-1:0] stamp,
  output logic [TIME_W:0]   elapsed
);
  logic [TIME_W:0] max_t;
  assign max_t = {1'b0, {TIME_W{1'b1}}};

  always_comb begin
    if (now >= stamp) elapsed = {1'b0, now} - {1'b0, stamp};
    else              elapsed = (max_t - {1'b0, stamp}) + {1'b0, now} + (TIME_W+1)'(1);
  end
endmodule

// File: rtl/slot_billing_ctrl.sv
// Parking lot controller: grants slots on entry, bills elapsed ticks on exit.
module slot_billing_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int RATE      = RATE_DEF,
  parameter int FEE_CAP   = FEE_CAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] current_time,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic       entry_ack,
  output logic [1:0] entry_slot,
  output logic       entry_nack,
  output logic       fee_valid,
  output logic [9:0] fee,
  output logic       exit_err,
  output logic [2:0] occupied,
  output logic       full
);
  state_e                            state_q, state_d;
  logic                              rr_q, rr_d;          // 1: exit has priority on collision
  logic                              svc_exit_q, svc_exit_d;
  logic [NUM_SLOTS-1:0]              valid_q, valid_d;
  logic [NUM_SLOTS-1:0][TIME_W-1:0]  stamp_q, stamp_d;
  logic [TIME_W:0]                   elapsed_q, elapsed_d;
  logic                              entry_ack_q, entry_ack_d;
  logic [1:0]                        entry_slot_q, entry_slot_d;
  logic                              entry_nack_q, entry_nack_d;
  logic                              fee_valid_q, fee_valid_d;
  logic [FEE_W-1:0]                  fee_q, fee_d;
  logic                              exit_err_q, exit_err_d;
  logic [2:0]                        occupied_q, occupied_d;
  logic                              full_q, full_d;

  logic [TIME_W:0] el_w;
  logic [2:0]      occ_cnt;
  logic            free_found;
  logic [1:0]      free_idx;

  elapsed_calc u_elapsed (
    .now     (current_time),
    .stamp   (stamp_q[exit_slot]),
    .elapsed (el_w)
  );

  always_comb begin
    occ_cnt    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      occ_cnt = occ_cnt + 3'(valid_q[i]);
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    svc_exit_d   = svc_exit_q;
    valid_d      = valid_q;
    stamp_d      = stamp_q;
    elapsed_d    = elapsed_q;
    fee_d        = fee_q;
    entry_ack_d  = 1'b0;
    entry_slot_d = '0;
    entry_nack_d = 1'b0;
    fee_valid_d  = 1'b0;
    exit_err_d   = 1'b0;
    occupied_d   = occ_cnt;
    full_d       = (occ_cnt == 3'(NUM_SLOTS));

    case (state_q)
      IDLE: begin
        if (entry_req && exit_req) begin
          state_d    = rr_q ? EXIT_CALC : ENTRY;
          svc_exit_d = rr_q;
          rr_d       = ~rr_q;
        end else if (entry_req) begin
          state_d    = ENTRY;
          svc_exit_d = 1'b0;
        end else if (exit_req) begin
          state_d    = EXIT_CALC;
          svc_exit_d = 1'b1;
        end
      end
      ENTRY: begin
        if (free_found) begin
          valid_d[free_idx] = 1'b1;
          stamp_d[free_idx] = current_time;
          entry_ack_d       = 1'b1;
          entry_slot_d      = free_idx;
        end else begin
          entry_nack_d = 1'b1;
        end
        state_d = RELEASE;
      end
      EXIT_CALC: begin
        if (!valid_q[exit_slot]) begin
          exit_err_d = 1'b1;
          state_d    = RELEASE;
        end else begin
          elapsed_d = el_w;
          state_d   = EXIT_DONE;
        end
      end
      EXIT_DONE: begin
        fee_d              = cap_fee(elapsed_q, RATE, FEE_CAP);
        fee_valid_d        = 1'b1;
        valid_d[exit_slot] = 1'b0;
        state_d            = RELEASE;
      end
      RELEASE: begin
        if (svc_exit_q ? !exit_req : !entry_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      svc_exit_q   <= 1'b0;
      valid_q      <= '0;
      stamp_q      <= '0;
      elapsed_q    <= '0;
      entry_ack_q  <= 1'b0;
      entry_slot_q <= '0;
      entry_nack_q <= 1'b0;
      fee_valid_q  <= 1'b0;
      fee_q        <= '0;
      exit_err_q   <= 1'b0;
      occupied_q   <= '0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      svc_exit_q   <= svc_exit_d;
      valid_q      <= valid_d;
      stamp_q      <= stamp_d;
      elapsed_q    <= elapsed_d;
      entry_ack_q  <= entry_ack_d;
      entry_slot_q <= entry_slot_d;
      entry_nack_q <= entry_nack_d;
      fee_valid_q  <= fee_valid_d;
      fee_q        <= fee_d;
      exit_err_q   <= exit_err_d;
      occupied_q   <= occupied_d;
      full_q       <= full_d;
    end
  end

  assign entry_ack  = entry_ack_q;
  assign entry_slot = entry_slot_q;
  assign entry_nack = entry_nack_q;
  assign fee_valid  = fee_valid_q;
  assign fee        = fee_q;
  assign exit_err   = exit_err_q;
  assign occupied   = occupied_q;
  assign full       = full_q;
endmodule

// File: tb/tb_slot_billing_ctrl.sv
// Directed bench for slot_billing_ctrl; a RATE=4 twin exercises the fee cap.
module tb_slot_billing_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] current_time = '0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_slot = '0;

  logic       entry_ack, entry_nack, fee_valid, exit_err, full;
  logic [1:0] entry_slot;
  logic [9:0] fee;
  logic [2:0] occupied;
  logic       entry_ack4, entry_nack4, fee_valid4, exit_err4, full4;
  logic [1:0] entry_slot4;
  logic [9:0] fee4;
  logic [2:0] occupied4;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  slot_billing_ctrl #(.NUM_SLOTS(4), .RATE(2), .FEE_CAP(400)) dut (
    .clk(clk), .reset(reset), .current_time(current_time),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack), .entry_slot(entry_slot), .entry_nack(entry_nack),
    .fee_valid(fee_valid), .fee(fee), .exit_err(exit_err),
    .occupied(occupied), .full(full)
  );

  slot_billing_ctrl #(.NUM_SLOTS(4), .RATE(4), .FEE_CAP(400)) dut4 (
    .clk(clk), .reset(reset), .current_time(current_time),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack4), .entry_slot(entry_slot4), .entry_nack(entry_nack4),
    .fee_valid(fee_valid4), .fee(fee4), .exit_err(exit_err4),
    .occupied(occupied4), .full(full4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(entry_ack || entry_nack || fee_valid || exit_err) && n < budget);
  endtask

  task automatic do_entry(input logic [7:0] t, input logic exp_nack,
                          input logic [1:0] exp_slot, input logic [2:0] exp_occ);
    int n;
    current_time = t;
    entry_req = 1'b1;
    wait_evt(8, n);
    chk("entry_latency", n, 2);
    chk("entry_ack", entry_ack, !exp_nack);
    chk("entry_nack", entry_nack, exp_nack);
    chk("entry_nack_r4", entry_nack4, exp_nack);
    if (!exp_nack) begin
      chk("entry_slot", entry_slot, exp_slot);
      chk("entry_slot_r4", entry_slot4, exp_slot);
    end
    entry_req = 1'b0;
    tick();
    chk("entry_ack_pulse", entry_ack, 0);
    chk("occupied_after_entry", occupied, exp_occ);
    chk("occupied_after_entry_r4", occupied4, exp_occ);
  endtask

  task automatic do_exit(input logic [7:0] t, input logic [1:0] slot, input logic exp_err,
                         input logic [9:0] exp_fee, input logic [9:0] exp_fee4,
                         input logic [2:0] exp_occ);
    int n;
    current_time = t;
    exit_slot = slot;
    exit_req = 1'b1;
    wait_evt(8, n);
    chk("exit_latency", n, exp_err ? 2 : 3);
    chk("exit_err", exit_err, exp_err);
    chk("exit_err_r4", exit_err4, exp_err);
    chk("fee_valid", fee_valid, !exp_err);
    if (!exp_err) begin
      chk("fee", fee, exp_fee);
      chk("fee_r4", fee4, exp_fee4);
      chk("fee_valid_r4", fee_valid4, 1);
    end
    exit_req = 1'b0;
    tick();
    chk("fee_valid_pulse", fee_valid, 0);
    if (!exp_err) chk("fee_hold", fee, exp_fee);
    chk("occupied_after_exit", occupied, exp_occ);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_occupied", occupied, 0);
    chk("rst_full", full, 0);
    chk("rst_fee", fee, 0);
    chk("rst_entry_ack", entry_ack, 0);
    chk("rst_fee_valid", fee_valid, 0);
    reset = 1'b1;
    tick();

    // basic entry at 10, exit at 40: elapsed 30
    do_entry(8'd10, 1'b0, 2'd0, 3'd1);
    do_exit(8'd40, 2'd0, 1'b0, 10'd60, 10'd120, 3'd0);

    // wrap: 250 -> 5 is 11 ticks
    do_entry(8'd250, 1'b0, 2'd0, 3'd1);
    do_exit(8'd5, 2'd0, 1'b0, 10'd22, 10'd44, 3'd0);

    // same-tick exit bills nothing
    do_entry(8'd77, 1'b0, 2'd0, 3'd1);
    do_exit(8'd77, 2'd0, 1'b0, 10'd0, 10'd0, 3'd0);

    // fill the lot, then one more
    do_entry(8'd0, 1'b0, 2'd0, 3'd1);
    do_entry(8'd0, 1'b0, 2'd1, 3'd2);
    do_entry(8'd0, 1'b0, 2'd2, 3'd3);
    chk("not_full_at_3", full, 0);
    do_entry(8'd0, 1'b0, 2'd3, 3'd4);
    chk("full_at_4", full, 1);
    chk("full_at_4_r4", full4, 1);
    do_entry(8'd0, 1'b1, 2'd0, 3'd4);
    chk("full_after_nack", full, 1);

    // fee cap: elapsed 200 hits exactly 400; elapsed 150 caps only at RATE 4
    do_exit(8'd200, 2'd1, 1'b0, 10'd400, 10'd400, 3'd3);
    chk("full_cleared", full, 0);
    do_exit(8'd150, 2'd2, 1'b0, 10'd300, 10'd400, 3'd2);

    // exit of an empty slot
    do_exit(8'd150, 2'd2, 1'b1, 10'd0, 10'd0, 3'd2);

    // first collision: entry wins, pending exit follows
    current_time = 8'd160;
    exit_slot = 2'd3;
    entry_req = 1'b1;
    exit_req = 1'b1;
    wait_evt(8, lat);
    chk("coll1_latency", lat, 2);
    chk("coll1_entry_ack", entry_ack, 1);
    chk("coll1_no_fee", fee_valid, 0);
    chk("coll1_slot", entry_slot, 1);
    entry_req = 1'b0;
    wait_evt(8, lat);
    chk("coll1_exit_latency", lat, 4);
    chk("coll1_fee_valid", fee_valid, 1);
    chk("coll1_fee", fee, 320);
    chk("coll1_fee_r4", fee4, 400);
    exit_req = 1'b0;
    tick();
    chk("coll1_occupied", occupied, 2);

    // second collision: exit wins, pending entry reuses the freed slot
    current_time = 8'd170;
    exit_slot = 2'd0;
    entry_req = 1'b1;
    exit_req = 1'b1;
    wait_evt(8, lat);
    chk("coll2_latency", lat, 3);
    chk("coll2_fee_valid", fee_valid, 1);
    chk("coll2_no_ack", entry_ack, 0);
    chk("coll2_fee", fee, 340);
    exit_req = 1'b0;
    wait_evt(8, lat);
    chk("coll2_entry_latency", lat, 3);
    chk("coll2_entry_ack", entry_ack, 1);
    chk("coll2_slot", entry_slot, 0);
    entry_req = 1'b0;
    tick();
    chk("coll2_occupied", occupied, 2);

    // reset while in EXIT_DONE drops the fee
    current_time = 8'd180;
    exit_slot = 2'd1;
    exit_req = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exit_req = 1'b0;
    tick();
    chk("midrst_fee_valid", fee_valid, 0);
    chk("midrst_fee", fee, 0);
    chk("midrst_occupied", occupied, 0);
    chk("midrst_full", full, 0);
    chk("midrst_exit_err", exit_err, 0);
    reset = 1'b1;
    tick();
    chk("postrst_fee_valid", fee_valid, 0);

    // after reset entry again wins a collision and the table starts empty
    current_time = 8'd190;
    exit_slot = 2'd0;
    entry_req = 1'b1;
    exit_req = 1'b1;
    wait_evt(8, lat);
    chk("rr_reset_entry_ack", entry_ack, 1);
    chk("rr_reset_slot", entry_slot, 0);
    entry_req = 1'b0;
    wait_evt(8, lat);
    chk("rr_reset_exit_fee_valid", fee_valid, 1);
    chk("rr_reset_exit_fee", fee, 0);
    exit_req = 1'b0;
    tick();
    chk("final_occupied", occupied, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/slot_billing_ctrl.md
SLOT_BILLING_CTRL -- requirements
Module: slot_billing_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of parking slots tracked; slot index width 2.
REQ-002 Parameter RATE, default 2: fee units charged per elapsed time tick.
REQ-003 Parameter FEE_CAP, default 400: maximum fee charged per exit.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 current_time  input  8  free-running time tick; wraps from 255 to 0.
REQ-007 entry_req  input  1  entry gate request; level, held until entry_ack or entry_nack.
REQ-008 exit_req  input  1  exit gate request; level, held until fee_valid or exit_err.
REQ-009 exit_slot  input  2  slot being vacated; stable while exit_req is high.
REQ-010 entry_ack  output  1  one-cycle pulse: slot granted.
REQ-011 entry_slot  output  2  granted slot index; valid while entry_ack is high.
REQ-012 entry_nack  output  1  one-cycle pulse: lot full, request refused.
REQ-013 fee_valid  output  1  one-cycle pulse: fee is valid.
REQ-014 fee  output  10  charge for the completed exit; holds its value until the next fee_valid.
REQ-015 exit_err  output  1  one-cycle pulse: exit_slot not occupied.
REQ-016 occupied  output  3  count of occupied slots, 0..NUM_SLOTS.
REQ-017 full  output  1  high when occupied equals NUM_SLOTS.

Function
REQ-018 FSM states: IDLE, ENTRY, EXIT_CALC, EXIT_DONE, RELEASE.
REQ-019 Per-slot state SHALL be a valid bit plus an 8-bit entry timestamp.
REQ-020 IDLE, entry_req only: the block SHALL go to ENTRY on the next edge.
REQ-021 IDLE, exit_req only: the block SHALL go to EXIT_CALC on the next edge.
REQ-022 IDLE, both requests: the block SHALL grant the requester not granted last (round-robin flag; entry wins after reset), then toggle the flag.
REQ-023 ENTRY, free slot exists: the block SHALL pick the lowest-index invalid slot, set valid, store current_time, pulse entry_ack with entry_slot, and go to RELEASE.
REQ-024 ENTRY, lot full: the block SHALL pulse entry_nack, leave the table unchanged, and go to RELEASE.
REQ-025 EXIT_CALC, slot invalid: the block SHALL pulse exit_err and go to RELEASE.
REQ-026 EXIT_CALC, slot valid: the block SHALL register elapsed = current_time - stamp when current_time >= stamp, else (255 - stamp) + current_time + 1, in 9 bits, then go to EXIT_DONE.
REQ-027 EXIT_DONE: fee SHALL be min(elapsed*RATE, FEE_CAP), computed at 10 bits or wider with no truncation before the compare.
REQ-028 EXIT_DONE: the block SHALL pulse fee_valid, clear the slot's valid bit, and go to RELEASE.
REQ-029 Elapsed 0 (exit on the same tick as entry) SHALL give fee 0.
REQ-030 Latency: entry_ack/entry_nack SHALL be visible 2 cycles after request sampled; exit_err 2 cycles; fee_valid 3 cycles.
REQ-031 RELEASE SHALL wait until the serviced request is low, then return to IDLE; the other requester stays pending.
REQ-032 occupied and full SHALL update in the cycle after the valid-bit change.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 reset low at a clock edge: FSM to IDLE, all valid bits and stamps cleared, round-robin flag to entry, and all outputs to 0, including mid-transaction; in-flight requests are dropped.

Structure
REQ-035 Package parking_pkg SHALL hold the FSM state enum, TIME_W=8, FEE_W=10, and the RATE/FEE_CAP defaults.
REQ-036 One sub-module, elapsed_calc (combinational wrap-aware subtraction, 8-bit in, 9-bit out), SHALL be instantiated in EXIT_CALC.

Verification
REQ-037 Entry at current_time=10, exit slot 0 at 40 -> entry_ack slot 0; fee=60, fee_valid after 3 cycles.
REQ-038 Wrap: entry at 250, exit at 5 -> elapsed 11, fee 22.
REQ-039 Four entries, then a fifth -> slots 0,1,2,3 granted, full=1, fifth gets entry_nack, table unchanged.
REQ-040 Entry and exit requests raised in the same cycle twice -> entry serviced first, exit second; the next collision serves exit first.
REQ-041 Exit of an empty slot 2 -> exit_err pulse, occupied unchanged; RATE=4, elapsed 200 -> fee capped at 400.
REQ-042 reset low during EXIT_DONE -> no fee_valid; occupied=0 and all outputs 0 on the next cycle.
